// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : alu_pkg                                                     |
// | Purpose : Shared types and constants for the handshaked sequential    |
// |           ALU (alu_seq) and its iterative multiplier (alu_mul_iter).  |
// | Contents: alu_op_t    - 3-bit operation encodings                     |
// |           alu_state_t - control FSM states                            |
// |           FLAG_*      - bit positions inside the 4-bit {N,Z,C,V} bus  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_MUL = 3'b110,
      OP_RSV = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } alu_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_mul_iter                                                |
// | Purpose : Shift-add multiplier, one bit of the multiplier per cycle.  |
// |           Produces the low WIDTH bits of a*b after WIDTH iterations.  |
// | Ports   : clk, reset (async, active-high)                             |
// |           start_i          - latch a_i/b_i and begin iterating        |
// |           a_i, b_i         - operands                                 |
// |           done_o           - high in the cycle of the final iteration |
// |           product_o        - valid while done_o is high               |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int             CW     = $clog2(WIDTH);
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [CW-1:0]    cnt_q;
   logic             run_q;

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   // The final partial product is folded in combinationally so the parent
   // can register the finished product on the same edge as iteration WIDTH.
   assign done_o    = run_q && (cnt_q == C_LAST);
   assign product_o = acc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (done_o) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_seq                                                     |
// | Purpose : Registered ALU with valid/ready handshakes on both sides.   |
// |           ADD/SUB/AND/OR/XOR/SLT complete in one cycle; MUL iterates  |
// |           for WIDTH cycles when the multiplier is compiled in.        |
// | Ports   : clk, reset (async, active-high)                             |
// |           in_valid/in_ready, a, b, op   - operation channel           |
// |           out_valid/out_ready, result, flags {N,Z,C,V} - result chan. |
// |           busy                          - high while multiplying      |
// | Config  : ALU_MUL_EN - compiles in the MUL state and alu_mul_iter;    |
// |           when undefined op 110 acts as reserved and busy is 0.       |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   alu_op_t          w_op;
   logic             w_accept;
   logic             w_is_mul;
   logic [WIDTH:0]   w_sum_add;
   logic [WIDTH:0]   w_sum_sub;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic [3:0]       w_flags;

   assign w_op = alu_op_t'(op);

   // Depends only on state and out_ready, never on in_valid.
   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (state_q == ST_HOLD);
   assign result    = result_q;
   assign flags     = flags_q;

   assign w_sum_add = {1'b0, a} + {1'b0, b};
   assign w_sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   // Single-cycle datapath
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_res = w_sum_add[WIDTH-1:0];
            w_c   = w_sum_add[WIDTH];
            w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sum_sub[WIDTH-1:0];
            w_c   = w_sum_sub[WIDTH];
            w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: w_res = '0;
      endcase
   end

   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_N] = w_res[WIDTH-1];
      w_flags[FLAG_Z] = (w_res == '0);
      w_flags[FLAG_C] = w_c;
      w_flags[FLAG_V] = w_v;
   end

`ifdef ALU_MUL_EN
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_prod;

   assign w_is_mul = (w_op == OP_MUL);
   assign busy     = (state_q == ST_MUL);

   alu_mul_iter #(
      .WIDTH     (WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (w_mul_start),
      .a_i       (a),
      .b_i       (b),
      .done_o    (w_mul_done),
      .product_o (w_mul_prod)
   );
`else
   assign w_is_mul = 1'b0;
   assign busy     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_MUL_EN
      w_mul_start = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (w_accept) begin
               if (w_is_mul) begin
                  state_d = ST_MUL;
`ifdef ALU_MUL_EN
                  w_mul_start = 1'b1;
`endif
               end else begin
                  state_d  = ST_HOLD;
                  result_d = w_res;
                  flags_d  = w_flags;
               end
            end else if ((state_q == ST_HOLD) && out_ready) begin
               state_d = ST_IDLE;
            end
         end
`ifdef ALU_MUL_EN
         ST_MUL: begin
            if (w_mul_done) begin
               state_d         = ST_HOLD;
               result_d        = w_mul_prod;
               flags_d         = '0;
               flags_d[FLAG_N] = w_mul_prod[WIDTH-1];
               flags_d[FLAG_Z] = (w_mul_prod == '0);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_alu_seq                                                  |
// | Purpose : Self-checking bench for alu_seq (WIDTH=32). A behavioural   |
// |           model tracks out_valid/busy/in_ready/result/flags from the  |
// |           accepted operations; directed vectors pin literal values.   |
// | Config  : follows ALU_MUL_EN like the design.                         |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_alu_seq;

   localparam int W = 32;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;
   logic         busy;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic in plain wide integer terms.
   function automatic void calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [3:0] f);
      logic [63:0] ux, uy, t;
      longint      sx, sy, st;
      logic        c, v;
      ux = {32'd0, x};
      uy = {32'd0, y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (o)
         3'd0: begin
            t = ux + uy; r = t[31:0]; c = (t >= 64'h1_0000_0000);
            st = sx + sy; v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
         end
         3'd1: begin
            t = ux - uy; r = t[31:0]; c = (ux >= uy);
            st = sx - sy; v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
         end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = (sx < sy) ? 32'd1 : 32'd0;
         3'd6: begin
            t = ux * uy;
            r = MUL_EN ? t[31:0] : 32'd0;
         end
         default: r = '0;
      endcase
      f = {r[W-1], (r == 0), c, v};
   endfunction

   // Model state
   logic         m_valid = 1'b0, m_busy = 1'b0;
   int           m_left  = 0;
   logic [W-1:0] m_res = '0, m_pres = '0;
   logic [3:0]   m_flags = '0, m_pflags = '0;

   always @(posedge clk or posedge reset) begin
      logic         rdy;
      logic [W-1:0] r;
      logic [3:0]   f;
      if (reset) begin
         m_valid = 1'b0;
         m_busy  = 1'b0;
         m_left  = 0;
         m_res   = '0;
         m_flags = '0;
      end else begin
         rdy = !m_busy && (!m_valid || out_ready);
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy  = 1'b0;
               m_valid = 1'b1;
               m_res   = m_pres;
               m_flags = m_pflags;
            end
         end else if (in_valid && rdy) begin
            calc(op, a, b, r, f);
            if (MUL_EN && op == 3'd6) begin
               m_busy   = 1'b1;
               m_left   = W;
               m_valid  = 1'b0;
               m_pres   = r;
               m_pflags = f;
            end else begin
               m_valid = 1'b1;
               m_res   = r;
               m_flags = f;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("cmp_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("cmp_busy", {63'd0, busy}, {63'd0, m_busy});
      chk("cmp_in_ready", {63'd0, in_ready}, {63'd0, (!m_busy && (!m_valid || out_ready))});
      if (m_valid) begin
         chk("cmp_result", {32'd0, result}, {32'd0, m_res});
         chk("cmp_flags", {60'd0, flags}, {60'd0, m_flags});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an op and hold it until accepted; returns at accept edge + 1.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      op       = o;
      a        = x;
      b        = y;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got no accept expected accept within 100 cycles");
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic single(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er, input logic [3:0] ef);
      issue(o, x, y);
      @(negedge clk);
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({name, "_result"}, {32'd0, result}, {32'd0, er});
      chk({name, "_flags"}, {60'd0, flags}, {60'd0, ef});
      step();
   endtask

   task automatic mul_run(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic [3:0] ef);
      int n;
      n = 0;
      issue(3'd6, x, y);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) break;
         chk({name, "_busy"}, {63'd0, busy}, 64'd1);
         @(posedge clk);
         n++;
      end
      chk({name, "_latency"}, 64'(n), MUL_EN ? 64'd32 : 64'd0);
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({name, "_busy_done"}, {63'd0, busy}, 64'd0);
      chk({name, "_result"}, {32'd0, result}, {32'd0, er});
      chk({name, "_flags"}, {60'd0, flags}, {60'd0, ef});
      step();
   endtask

   initial begin
      logic [W-1:0] exp_q[8];
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 3'd0;
      a         = '0;
      b         = '0;
      reset     = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_result", {32'd0, result}, 64'd0);
      chk("rst_flags", {60'd0, flags}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      reset = 1'b0;
      step();

      single("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
      single("sub_ovf", 3'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011);
      single("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0000);
      single("xor", 3'd4, 32'hA5A5_0000, 32'hFFFF_0000, 32'h5A5A_0000, 4'b0000);
      single("rsv", 3'd7, 32'h1234, 32'h5678, 32'h0, 4'b0100);

      mul_run("mul_7x6", 32'd7, 32'd6, MUL_EN ? 32'd42 : 32'd0, MUL_EN ? 4'b0000 : 4'b0100);
      mul_run("mul_wrap", 32'h1_0000, 32'h1_0000, 32'h0, 4'b0100);

      // Backpressure: result must be held while out_ready is low
      out_ready = 1'b0;
      issue(3'd2, 32'hF0F0, 32'hFF00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_result", {32'd0, result}, 64'h F000);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      out_ready = 1'b1;
      issue(3'd0, 32'd5, 32'd3);
      @(negedge clk);
      chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_next_result", {32'd0, result}, 64'd8);
      step();

      // Back-to-back ADDs, one result per cycle
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         op       = 3'd0;
         a        = 32'h100 * i + 32'd1;
         b        = 32'd2 * i;
         exp_q[i] = 32'h100 * i + 32'd1 + 32'd2 * i;
         @(negedge clk);
         chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
         if (i > 0) begin
            chk("b2b_valid", {63'd0, out_valid}, 64'd1);
            chk("b2b_result", {32'd0, result}, {32'd0, exp_q[i-1]});
         end
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_last_valid", {63'd0, out_valid}, 64'd1);
      chk("b2b_last_result", {32'd0, result}, {32'd0, exp_q[7]});
      step();

      // Reset in the middle of a multiply
      issue(3'd6, 32'd3, 32'd5);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rstmul_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rstmul_busy", {63'd0, busy}, 64'd0);
      chk("rstmul_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      step();
      single("post_rst_add", 3'd0, 32'd2, 32'd2, 32'd4, 4'b0000);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU that replaces the purely combinational 32-bit ALU for datapaths needing registered results, wider operand widths, extra operations and an optional iterative multiplier. It accepts one operation per cycle over a valid/ready input channel. It returns the result with N/Z/C/V flags over a valid/ready output channel. Single-cycle operations run at full throughput; MUL occupies the unit for WIDTH cycles.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept this cycle
- a, b  in  WIDTH  operands
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 MUL, 111 reserved
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- flags  out  4  {N,Z,C,V}, registered with result
- busy  out  1  high while in MUL state

## Operation
- States:
  - IDLE: no pending result.
  - MUL: iterating.
  - HOLD: out_valid=1.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready.
- Single-cycle accept: result/flags registered, state→HOLD.
- MUL accept: operands latched, counter=0, state→MUL. Shift-add, one bit of b per cycle. After WIDTH iterations, state→HOLD with low WIDTH bits of the product.
- HOLD & out_ready & no accept → IDLE. HOLD & accept → new result (single-cycle) or MUL.
- Arithmetic:
  - ADD: sum = a + b, computed WIDTH+1 wide. C = carry-out. V = operands same sign and result sign differs.
  - SUB: a + ~b + 1. C = carry-out (1 = no borrow). V = operand signs differ and result sign ≠ a sign.
  - AND/OR/XOR/SLT/MUL/reserved: C=V=0.
  - SLT: result = 1 if signed a < signed b, else 0.
  - Reserved op: result = 0.
- N = result[WIDTH-1]. Z = (result == 0), for every op.
- Outputs are stable while out_valid & !out_ready.
- Reset mid-MUL: the operation is discarded with no output.

## Timing
- Reset values:
  - state=IDLE.
  - out_valid=0, result=0, flags=0, busy=0.
  - in_ready=1, since it is combinational from state.
- Single-cycle op accepted at edge e: out_valid high after e, so latency is 1 cycle.
- MUL accepted at edge e: busy=1 after e. out_valid high after edge e+WIDTH; busy drops at the same edge.
- Throughput: 1 op/cycle for single-cycle ops with out_ready held high; no bubble between results.
- in_ready is 0 throughout MUL. In_ready is also 0 in HOLD while out_ready=0.
- in_ready depends combinationally on out_ready; there is no path from in_valid to in_ready.

## Configuration
- ALU_MUL_EN defined: MUL datapath, MUL state and counter are compiled in.
- ALU_MUL_EN undefined: op 110 behaves as reserved (single cycle, result 0, Z=1). busy is tied 0 and the multiplier sub-module is not instantiated.

## Structure
- alu_pkg holds:
  - alu_op_t enum (3-bit encodings above).
  - alu_state_t enum {IDLE, MUL, HOLD}.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_mul_iter(WIDTH):
  - Shift-add core with start and done signals.
  - Its own reset-cleared counter.
  - Instantiated only under ALU_MUL_EN.

## Test plan (WIDTH=32, ALU_MUL_EN defined)
- ADD 0xFFFFFFFF + 0x1 → result 0x0, flags N0 Z1 C1 V0; out_valid one cycle after accept.
- SUB 0x80000000 − 0x1 → 0x7FFFFFFF, N0 Z0 C1 V1. SLT 0xFFFFFFFF vs 0x1 → 0x1, flags 0000.
- MUL 7 × 6 → 42, out_valid exactly 32 cycles after accept, busy high meanwhile. MUL 0x10000 × 0x10000 → 0x0 with Z=1.
- Backpressure: hold out_ready=0 after an AND 0xF0F0 & 0xFF00 → result 0xF000 held and in_ready=0. Release out_ready with the next op valid → new result follows with no bubble.
- Back-to-back: 8 ADDs issued with out_ready=1 → 8 results on 8 consecutive cycles in order.
- Assert reset mid-MUL at cycle 10 → out_valid=0, busy=0, in_ready=1 immediately. The next ADD after reset completes normally.
